// File: rtl/blake_state_writeback_if.sv
// Handshake and data bundle between a BLAKE-512 round driver and the state
// writeback block: initial state load, G-lane results and the working state.
interface blake_state_writeback_if;
   logic          init_valid;
   logic [1023:0] v_init;
   logic          g_valid;
   logic [63:0]   a1_out, b1_out, c1_out, d1_out;
   logic [63:0]   a2_out, b2_out, c2_out, d2_out;
   logic [1023:0] v_out;
   logic [5:0]    counter_idx;
   logic          busy;
   logic          done;

   modport master (
      output init_valid, v_init, g_valid,
      output a1_out, b1_out, c1_out, d1_out,
      output a2_out, b2_out, c2_out, d2_out,
      input  v_out, counter_idx, busy, done
   );

   modport slave (
      input  init_valid, v_init, g_valid,
      input  a1_out, b1_out, c1_out, d1_out,
      input  a2_out, b2_out, c2_out, d2_out,
      output v_out, counter_idx, busy, done
   );
endinterface

// File: rtl/blake_state_writeback.sv
// BLAKE-512 working-state register: loads v0..v15, then scatters two G lanes per
// step (columns 0/1, columns 2/3, diagonals 0/1, diagonals 2/3) for ROUNDS rounds.
module blake_state_writeback #(
   parameter int ROUNDS = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   blake_state_writeback_if.slave bus
);

   localparam logic [5:0] LAST_IDX = 6'(4 * ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [63:0] v     [16];
   logic [63:0] v_nxt [16];
   logic [5:0]  cnt;
   logic        done_q;
   logic        load, wr, last;

   assign last = (cnt == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      wr        = 1'b0;
      case (state)
         IDLE, DONE: begin
            // init_valid takes priority; g_valid is never looked at outside RUN
            if (bus.init_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (bus.g_valid) begin
               wr = 1'b1;
               if (last) state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 16; i++) v_nxt[i] = v[i];
      if (load) begin
         for (int i = 0; i < 16; i++) v_nxt[i] = bus.v_init[1023 - 64*i -: 64];
      end else if (wr) begin
         case (cnt[1:0])
            2'd0: begin
               v_nxt[0]  = bus.a1_out; v_nxt[4]  = bus.b1_out;
               v_nxt[8]  = bus.c1_out; v_nxt[12] = bus.d1_out;
               v_nxt[1]  = bus.a2_out; v_nxt[5]  = bus.b2_out;
               v_nxt[9]  = bus.c2_out; v_nxt[13] = bus.d2_out;
            end
            2'd1: begin
               v_nxt[2]  = bus.a1_out; v_nxt[6]  = bus.b1_out;
               v_nxt[10] = bus.c1_out; v_nxt[14] = bus.d1_out;
               v_nxt[3]  = bus.a2_out; v_nxt[7]  = bus.b2_out;
               v_nxt[11] = bus.c2_out; v_nxt[15] = bus.d2_out;
            end
            2'd2: begin
               v_nxt[0]  = bus.a1_out; v_nxt[5]  = bus.b1_out;
               v_nxt[10] = bus.c1_out; v_nxt[15] = bus.d1_out;
               v_nxt[1]  = bus.a2_out; v_nxt[6]  = bus.b2_out;
               v_nxt[11] = bus.c2_out; v_nxt[12] = bus.d2_out;
            end
            default: begin
               v_nxt[2]  = bus.a1_out; v_nxt[7]  = bus.b1_out;
               v_nxt[8]  = bus.c1_out; v_nxt[13] = bus.d1_out;
               v_nxt[3]  = bus.a2_out; v_nxt[4]  = bus.b2_out;
               v_nxt[9]  = bus.c2_out; v_nxt[14] = bus.d2_out;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) v[i] <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= wr && last;
         if (load || wr) begin
            for (int i = 0; i < 16; i++) v[i] <= v_nxt[i];
         end
         // the final step wraps the index so a later reload starts clean
         if (load)      cnt <= '0;
         else if (wr)   cnt <= last ? 6'd0 : cnt + 6'd1;
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_pack
      assign bus.v_out[1023 - 64*i -: 64] = v[i];
   end

   assign bus.counter_idx = cnt;
   assign bus.busy        = (state == RUN);
   assign bus.done        = done_q;

endmodule

// File: tb/tb_blake_state_writeback.sv
// Directed bench: step placement, full-length runs for ROUNDS=16 and 1,
// RUN/IDLE/DONE input filtering and asynchronous reset.
module tb_blake_state_writeback;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;
   logic [63:0] e [16];
   int   done_cnt;

   always #5 clk = ~clk;

   blake_state_writeback_if ifa ();
   blake_state_writeback_if ifb ();

   blake_state_writeback #(.ROUNDS(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   blake_state_writeback #(.ROUNDS(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_v(input string tag, input logic [1023:0] got);
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s.v%0d", tag, i), got[1023 - 64*i -: 64], e[i]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ga(input logic [63:0] b);
      ifa.a1_out = b + 64'hA1; ifa.b1_out = b + 64'hB1;
      ifa.c1_out = b + 64'hC1; ifa.d1_out = b + 64'hD1;
      ifa.a2_out = b + 64'hA2; ifa.b2_out = b + 64'hB2;
      ifa.c2_out = b + 64'hC2; ifa.d2_out = b + 64'hD2;
   endtask

   task automatic set_gb(input logic [63:0] b);
      ifb.a1_out = b + 64'hA1; ifb.b1_out = b + 64'hB1;
      ifb.c1_out = b + 64'hC1; ifb.d1_out = b + 64'hD1;
      ifb.a2_out = b + 64'hA2; ifb.b2_out = b + 64'hB2;
      ifb.c2_out = b + 64'hC2; ifb.d2_out = b + 64'hD2;
   endtask

   // final state after any complete compression with constant G values b+xx
   task automatic set_final(input logic [63:0] b);
      e[0]  = b + 64'hA1; e[1]  = b + 64'hA2; e[2]  = b + 64'hA1; e[3]  = b + 64'hA2;
      e[4]  = b + 64'hB2; e[5]  = b + 64'hB1; e[6]  = b + 64'hB2; e[7]  = b + 64'hB1;
      e[8]  = b + 64'hC1; e[9]  = b + 64'hC2; e[10] = b + 64'hC1; e[11] = b + 64'hC2;
      e[12] = b + 64'hD2; e[13] = b + 64'hD1; e[14] = b + 64'hD2; e[15] = b + 64'hD1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      ifa.init_valid = 0; ifa.g_valid = 0; ifa.v_init = '0; set_ga(64'h0);
      ifb.init_valid = 0; ifb.g_valid = 0; ifb.v_init = '0; set_gb(64'h0);
      tick(); tick();
      for (int i = 0; i < 16; i++) e[i] = 64'h0;
      chk_v("rst", ifa.v_out);
      chk("rst_cnt",  64'(ifa.counter_idx), 64'd0);
      chk("rst_busy", 64'(ifa.busy), 64'd0);
      chk("rst_done", 64'(ifa.done), 64'd0);

      // g_valid in IDLE is ignored
      rst_n = 1'b1;
      tick();
      ifa.g_valid = 1; tick(); ifa.g_valid = 0;
      chk_v("idle_g", ifa.v_out);
      chk("idle_cnt",  64'(ifa.counter_idx), 64'd0);
      chk("idle_busy", 64'(ifa.busy), 64'd0);

      // load v_i = i
      for (int i = 0; i < 16; i++) begin
         ifa.v_init[1023 - 64*i -: 64] = 64'(i);
         e[i] = 64'(i);
      end
      ifa.init_valid = 1; tick(); ifa.init_valid = 0;
      chk_v("load", ifa.v_out);
      chk("load_cnt",  64'(ifa.counter_idx), 64'd0);
      chk("load_busy", 64'(ifa.busy), 64'd1);

      // step 0, columns 0/1
      set_ga(64'h0); ifa.g_valid = 1; tick(); ifa.g_valid = 0;
      e[0] = 64'hA1; e[4] = 64'hB1; e[8] = 64'hC1; e[12] = 64'hD1;
      e[1] = 64'hA2; e[5] = 64'hB2; e[9] = 64'hC2; e[13] = 64'hD2;
      chk_v("s0", ifa.v_out);
      chk("s0_cnt", 64'(ifa.counter_idx), 64'd1);

      // step 1, columns 2/3
      set_ga(64'h200); ifa.g_valid = 1; tick(); ifa.g_valid = 0;
      e[2] = 64'h2A1; e[6] = 64'h2B1; e[10] = 64'h2C1; e[14] = 64'h2D1;
      e[3] = 64'h2A2; e[7] = 64'h2B2; e[11] = 64'h2C2; e[15] = 64'h2D2;
      chk_v("s1", ifa.v_out);
      chk("s1_cnt", 64'(ifa.counter_idx), 64'd2);

      // step 2, diagonals 0/1
      set_ga(64'h0); ifa.g_valid = 1; tick(); ifa.g_valid = 0;
      e[0] = 64'hA1; e[5] = 64'hB1; e[10] = 64'hC1; e[15] = 64'hD1;
      e[1] = 64'hA2; e[6] = 64'hB2; e[11] = 64'hC2; e[12] = 64'hD2;
      chk_v("s2", ifa.v_out);
      chk("s2_cnt", 64'(ifa.counter_idx), 64'd3);

      // step 3, diagonals 2/3; carries into the round field
      ifa.g_valid = 1; tick(); ifa.g_valid = 0;
      e[2] = 64'hA1; e[7] = 64'hB1; e[8] = 64'hC1; e[13] = 64'hD1;
      e[3] = 64'hA2; e[4] = 64'hB2; e[9] = 64'hC2; e[14] = 64'hD2;
      chk_v("s3", ifa.v_out);
      chk("s3_cnt", 64'(ifa.counter_idx), 64'd4);

      // reach index 5, then init_valid mid-RUN must be ignored
      set_ga(64'h400); ifa.g_valid = 1; tick(); ifa.g_valid = 0;
      e[0] = 64'h4A1; e[4] = 64'h4B1; e[8] = 64'h4C1; e[12] = 64'h4D1;
      e[1] = 64'h4A2; e[5] = 64'h4B2; e[9] = 64'h4C2; e[13] = 64'h4D2;
      chk("r1s0_cnt", 64'(ifa.counter_idx), 64'd5);
      ifa.v_init = '1; ifa.init_valid = 1; tick(); ifa.init_valid = 0;
      chk_v("run_init", ifa.v_out);
      chk("run_init_cnt",  64'(ifa.counter_idx), 64'd5);
      chk("run_init_busy", 64'(ifa.busy), 64'd1);
      ifa.g_valid = 1; tick(); ifa.g_valid = 0;
      chk("run_next_cnt", 64'(ifa.counter_idx), 64'd6);

      // advance to index 30 and reset asynchronously mid-cycle
      ifa.g_valid = 1;
      repeat (24) tick();
      ifa.g_valid = 0;
      chk("pre_rst_cnt", 64'(ifa.counter_idx), 64'd30);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) e[i] = 64'h0;
      chk_v("async_rst", ifa.v_out);
      chk("async_rst_cnt",  64'(ifa.counter_idx), 64'd0);
      chk("async_rst_busy", 64'(ifa.busy), 64'd0);
      tick();
      rst_n = 1'b1;
      done_cnt = 0;
      ifa.g_valid = 1;
      for (int k = 0; k < 6; k++) begin
         tick();
         done_cnt += int'(ifa.done);
      end
      ifa.g_valid = 0;
      chk("post_rst_done", 64'(done_cnt), 64'd0);
      chk("post_rst_busy", 64'(ifa.busy), 64'd0);
      chk("post_rst_cnt",  64'(ifa.counter_idx), 64'd0);

      // full ROUNDS=16 compression: 64 back-to-back writes
      for (int i = 0; i < 16; i++) ifa.v_init[1023 - 64*i -: 64] = 64'(i);
      ifa.init_valid = 1; tick(); ifa.init_valid = 0;
      set_ga(64'h1000); ifa.g_valid = 1;
      done_cnt = 0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         done_cnt += int'(ifa.done);
         if (k < 64) chk($sformatf("run16_cnt%0d", k), 64'(ifa.counter_idx), 64'(k));
      end
      chk("run16_done", 64'(ifa.done), 64'd1);
      chk("run16_busy", 64'(ifa.busy), 64'd0);
      chk("run16_cnt",  64'(ifa.counter_idx), 64'd0);
      set_final(64'h1000);
      chk_v("run16_v", ifa.v_out);

      // DONE: g_valid ignored, state held, done only one cycle
      set_ga(64'h9000);
      tick();
      done_cnt += int'(ifa.done);
      tick();
      done_cnt += int'(ifa.done);
      ifa.g_valid = 0;
      chk("run16_done_once", 64'(done_cnt), 64'd1);
      chk_v("done_hold", ifa.v_out);
      chk("done_hold_cnt", 64'(ifa.counter_idx), 64'd0);

      // DONE: init_valid and g_valid together, init wins
      for (int i = 0; i < 16; i++) begin
         ifa.v_init[1023 - 64*i -: 64] = 64'hFEED_0000_0000_0000 + 64'(i);
         e[i] = 64'hFEED_0000_0000_0000 + 64'(i);
      end
      ifa.init_valid = 1; ifa.g_valid = 1; tick();
      ifa.init_valid = 0; ifa.g_valid = 0;
      chk_v("done_reload", ifa.v_out);
      chk("done_reload_cnt",  64'(ifa.counter_idx), 64'd0);
      chk("done_reload_busy", 64'(ifa.busy), 64'd1);

      // ROUNDS=1: four writes finish the compression
      ifb.init_valid = 1; tick(); ifb.init_valid = 0;
      set_gb(64'h3000); ifb.g_valid = 1;
      done_cnt = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         done_cnt += int'(ifb.done);
         if (k < 4) begin
            chk($sformatf("run1_cnt%0d", k), 64'(ifb.counter_idx), 64'(k));
            chk($sformatf("run1_busy%0d", k), 64'(ifb.busy), 64'd1);
         end
      end
      ifb.g_valid = 0;
      chk("run1_done", 64'(ifb.done), 64'd1);
      chk("run1_busy", 64'(ifb.busy), 64'd0);
      chk("run1_cnt",  64'(ifb.counter_idx), 64'd0);
      set_final(64'h3000);
      chk_v("run1_v", ifb.v_out);
      tick();
      done_cnt += int'(ifb.done);
      chk("run1_done_once", 64'(done_cnt), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/blake_state_writeback.md
BLAKE_STATE_WRITEBACK -- requirements
Module: blake_state_writeback

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, number of BLAKE-512 rounds per compression; legal range 1..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port init_valid  input  1  load v_init into the working state and start a compression.
REQ-005 SHALL have port v_init  input  1024  initial v0..v15; v_i occupies bits [1023-64i -: 64].
REQ-006 SHALL have port g_valid  input  1  the eight G results below are valid this cycle.
REQ-007 SHALL have ports a1_out, b1_out, c1_out, d1_out  input  64 each  lane-1 G results.
REQ-008 SHALL have ports a2_out, b2_out, c2_out, d2_out  input  64 each  lane-2 G results.
REQ-009 SHALL have port v_out  output  1024  registered working state, same packing as v_init.
REQ-010 SHALL have port counter_idx  output  6  registered step index: [1:0] = step, [5:2] = round.
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the final step has been written.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN and DONE->RUN on init_valid; RUN->DONE on the final write; DONE holds until init_valid.
REQ-014 On init_valid in IDLE or DONE, SHALL load v_out <= v_init and counter_idx <= 0, with busy high from the next cycle.
REQ-015 SHALL ignore init_valid while in RUN: no reload, no counter change.
REQ-016 SHALL ignore g_valid in IDLE and DONE: v_out and counter_idx unchanged.
REQ-017 On g_valid in RUN, SHALL write exactly eight words selected by counter_idx[1:0] and leave the other eight unchanged.
REQ-018 Step 0 (columns 0,1) SHALL write v0=a1, v4=b1, v8=c1, v12=d1, v1=a2, v5=b2, v9=c2, v13=d2.
REQ-019 Step 1 (columns 2,3) SHALL write v2=a1, v6=b1, v10=c1, v14=d1, v3=a2, v7=b2, v11=c2, v15=d2.
REQ-020 Step 2 (diagonals 0,1) SHALL write v0=a1, v5=b1, v10=c1, v15=d1, v1=a2, v6=b2, v11=c2, v12=d2.
REQ-021 Step 3 (diagonals 2,3) SHALL write v2=a1, v7=b1, v8=c1, v13=d1, v3=a2, v4=b2, v9=c2, v14=d2.
REQ-022 Each accepted g_valid SHALL increment counter_idx by 1 in the same edge as the write; a step 3 write carries into the round field.
REQ-023 A g_valid accepted when counter_idx == 4*ROUNDS-1 SHALL be the final write: the state moves to DONE, counter_idx wraps to 0, and done is high for exactly the next cycle.
REQ-024 Latency: each write SHALL be visible on v_out one cycle after g_valid, so a combinational selector on (v_out, counter_idx) sees the updated state for the next step.
REQ-025 v_out SHALL hold its final value in DONE until the next init_valid.
REQ-026 When init_valid and g_valid are both high in DONE, init_valid SHALL win; g_valid is ignored.

Reset
REQ-027 While rst_n is low, SHALL force state IDLE, v_out = 0, counter_idx = 0, busy = 0 and done = 0, asynchronously.
REQ-028 rst_n asserted mid-RUN SHALL abandon the compression with no done pulse; a new init_valid is required to restart.

Verification
REQ-029 Load v_init with v_i = i (64-bit), then apply g_valid in step 0 with a1..d2 = 0xA1,0xB1,0xC1,0xD1,0xA2,0xB2,0xC2,0xD2 -> v0=0xA1, v4=0xB1, v8=0xC1, v12=0xD1, v1=0xA2, v5=0xB2, v9=0xC2, v13=0xD2; all other v_i unchanged; counter_idx=1.
REQ-030 Repeat REQ-029 in steps 2 and 3 -> diagonal placement per REQ-020/021 (for example v12=0xD2 at step 2 and v4=0xB2 at step 3).
REQ-031 With ROUNDS=16, apply 64 back-to-back g_valid pulses -> done high on exactly one cycle after the 64th pulse, busy low, counter_idx=0; run the same check with ROUNDS=1 and 4 pulses.
REQ-032 Assert init_valid mid-RUN at counter_idx=5 -> no reload, counter_idx continues to 6 on the next g_valid; in IDLE, g_valid -> no change.
REQ-033 Drop rst_n at counter_idx=30 -> v_out=0, counter_idx=0, busy=0 immediately; no done pulse after release.
REQ-034 In DONE, assert init_valid and g_valid together -> v_out=v_init, counter_idx=0, busy=1.
